// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared constants, loader state encoding and fetch decode helper
package imem_boot_loader_pkg;

    localparam int IMEM_DEPTH = 4096;
    localparam int IMEM_AW    = 12;
    localparam int INSTR_BITS = 32;
    localparam int DATA_BITS  = 32;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_HDR  = 2'd1,
        LD_BODY = 2'd2,
        LD_RUN  = 2'd3
    } ld_state_t;

    // A fetch faults when it is not word aligned or falls beyond the imem window.
    function automatic logic fetch_fault_of(input logic [DATA_BITS-1:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream, imem write port and fetch read port of the boot loader
interface imem_boot_loader_if
    import imem_boot_loader_pkg::*;
#(
    parameter int AW = IMEM_AW
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [INSTR_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0]  fetch_addr;
    logic [AW-1:0]         mem_raddr;
    logic                  fetch_fault;

    modport master (
        output byte_valid, byte_data, fetch_addr,
        input  byte_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, fetch_fault
    );

    modport slave (
        input  byte_valid, byte_data, fetch_addr,
        output byte_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, fetch_fault
    );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// rtl/imem_boot_loader_byte_packer.sv - packs little-endian bytes into 32-bit words
module imem_boot_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic        byte_ready,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0] idx;
    logic [7:0] b0, b1, b2;
    logic       xfer;

    assign xfer = byte_valid && byte_ready;

    // The top byte is taken straight from the bus so the word is complete in the cycle
    // of its fourth transfer; the consumer registers it if it needs it later.
    assign word_valid = xfer && (idx == 2'd3);
    assign word       = {byte_data, b2, b1, b0};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx <= 2'd0;
            b0  <= 8'h00;
            b1  <= 8'h00;
            b2  <= 8'h00;
        end else if (xfer) begin
            case (idx)
                2'd0:    b0 <= byte_data;
                2'd1:    b1 <= byte_data;
                2'd2:    b2 <= byte_data;
                default: ;
            endcase
            idx <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot sequencer: loads imem from a byte stream, then releases fetch
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus,
    input  logic                load_start,
    output logic                cpu_stall,
    output logic                load_done,
    output logic                load_err,
    output logic [AW:0]         word_count
);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    ld_state_t             state, state_nxt;
    logic [AW:0]           n_words;
    logic                  wr_pend;
    logic [INSTR_BITS-1:0] wr_data;
    logic [31:0]           pk_word;
    logic                  pk_valid;
    logic                  accept_start;
    logic                  hdr_too_big;
    logic                  hdr_err;

    imem_boot_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept_start),
        .byte_valid (bus.byte_valid),
        .byte_ready (bus.byte_ready),
        .byte_data  (bus.byte_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    assign hdr_too_big = pk_word > DEPTH_W;
    assign hdr_err     = (state == LD_HDR) && pk_valid && hdr_too_big;

    assign bus.mem_we    = wr_pend && (state == LD_BODY);
    assign bus.mem_waddr = word_count[AW-1:0];
    assign bus.mem_wdata = wr_data;

    assign bus.mem_raddr   = bus.fetch_addr[AW+1:2];
    assign bus.fetch_fault = fetch_fault_of(bus.fetch_addr, AW);

    assign cpu_stall = (state != LD_RUN);

    always_comb begin
        state_nxt      = state;
        bus.byte_ready = 1'b0;
        accept_start   = 1'b0;
        case (state)
            LD_IDLE: begin
                if (load_start) begin
                    state_nxt    = LD_HDR;
                    accept_start = 1'b1;
                end
            end
            LD_HDR: begin
                bus.byte_ready = 1'b1;
                if (pk_valid) begin
                    if (pk_word == '0)    state_nxt = LD_RUN;
                    else if (hdr_too_big) state_nxt = LD_IDLE;
                    else                  state_nxt = LD_BODY;
                end
            end
            LD_BODY: begin
                bus.byte_ready = 1'b1;
                if (bus.mem_we && ((word_count + 1'b1) == n_words)) state_nxt = LD_RUN;
            end
            LD_RUN: begin
                if (load_start) begin
                    state_nxt    = LD_HDR;
                    accept_start = 1'b1;
                end
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LD_IDLE;
            n_words    <= '0;
            word_count <= '0;
            load_err   <= 1'b0;
            load_done  <= 1'b0;
            wr_pend    <= 1'b0;
            wr_data    <= '0;
        end else begin
            state     <= state_nxt;
            load_done <= (state_nxt == LD_RUN) && (state != LD_RUN);
            // The write lands one cycle after the fourth byte, leaving the packer free
            // to take the first byte of the next word in the write cycle.
            wr_pend   <= (state == LD_BODY) && pk_valid;
            if ((state == LD_BODY) && pk_valid) wr_data <= pk_word;
            if ((state == LD_HDR) && pk_valid) n_words <= pk_word[AW:0];
            if (accept_start) begin
                load_err   <= 1'b0;
                word_count <= '0;
            end else if (hdr_err) begin
                load_err <= 1'b1;
            end else if (bus.mem_we) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int DEPTH = IMEM_DEPTH;
    localparam int AW    = IMEM_AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        cpu_stall;
    logic        load_done;
    logic        load_err;
    logic [AW:0] word_count;

    imem_boot_loader_if #(.AW(AW)) bif ();

    imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif),
        .load_start (load_start),
        .cpu_stall  (cpu_stall),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed write and done events, stamped with the cycle they were seen in
    int          wr_cyc_q[$];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_q[$];

    // Reference: body words in send order and the cycle each word's last byte was accepted
    logic [31:0] exp_words[$];
    int          acc_cyc[$];

    always @(negedge clk) begin
        if (bif.mem_we === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(int'(bif.mem_waddr));
            wr_data_q.push_back(bif.mem_wdata);
        end
        if (load_done === 1'b1) done_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_q.delete();
        exp_words.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        load_start = 1'b0;
        bif.byte_valid = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        clear_mon;
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        int tries;
        tries = 0;
        acc = -1;
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        while (acc < 0 && tries < 8) begin
            @(negedge clk);
            if (bif.byte_ready === 1'b1) acc = cyc;
            tries++;
        end
        if (acc < 0) chk("byte_ready_timeout", 64'(bif.byte_ready), 64'(1));
        tick;
        bif.byte_valid = 1'b0;
    endtask

    task automatic send_bytes4(input logic [31:0] w, input int gap_max, output int acc4);
        int a;
        for (int k = 0; k < 4; k++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick;
            send_byte(8'((w >> (8 * k)) & 32'hFF), a);
        end
        acc4 = a;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        int a;
        send_bytes4(w, gap_max, a);
        exp_words.push_back(w);
        acc_cyc.push_back(a);
    endtask

    task automatic check_load(input string tag, input int n, input int hdr_cyc);
        int m;
        repeat (4) tick;
        chk({tag, "_nwr"}, 64'(wr_cyc_q.size()), 64'(n));
        m = (wr_cyc_q.size() < n) ? wr_cyc_q.size() : n;
        for (int i = 0; i < m; i++) begin
            chk({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
            chk({tag, "_data"}, 64'(wr_data_q[i]), 64'(exp_words[i]));
            chk({tag, "_wcyc"}, 64'(wr_cyc_q[i]), 64'(acc_cyc[i] + 1));
        end
        chk({tag, "_ndone"}, 64'(done_q.size()), 64'(1));
        if (done_q.size() > 0)
            chk({tag, "_donecyc"}, 64'(done_q[0]),
                64'((n == 0) ? hdr_cyc + 1 : acc_cyc[n-1] + 2));
        chk({tag, "_stall"}, 64'(cpu_stall), 64'(0));
        chk({tag, "_wcount"}, 64'(word_count), 64'(n));
        chk({tag, "_err"}, 64'(load_err), 64'(0));
    endtask

    task automatic do_load(input string tag, input int n, input int gap_max);
        int hc;
        pulse_start;
        send_bytes4(32'(n), gap_max, hc);
        for (int i = 0; i < n; i++) send_word($urandom, gap_max);
        check_load(tag, n, hc);
    endtask

    task automatic chk_fetch(input logic [31:0] a);
        bif.fetch_addr = a;
        #1;
        chk("fetch_raddr", 64'(bif.mem_raddr), 64'((a >> 2) % DEPTH));
        chk("fetch_fault", 64'(bif.fetch_fault), 64'((a % 4 != 0) || (a >= 4 * DEPTH)));
    endtask

    initial begin
        int hc;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        bif.fetch_addr = '0;
        load_start     = 1'b0;
        do_reset;

        chk("rst_stall", 64'(cpu_stall), 64'(1));
        chk("rst_ready", 64'(bif.byte_ready), 64'(0));
        chk("rst_we", 64'(bif.mem_we), 64'(0));
        chk("rst_done", 64'(load_done), 64'(0));
        chk("rst_err", 64'(load_err), 64'(0));
        chk("rst_wcount", 64'(word_count), 64'(0));
        for (int i = 0; i < 4; i++) chk_fetch($urandom);
        tick;

        // Two-word program with the reference words
        pulse_start;
        send_bytes4(32'd2, 1, hc);
        send_word(32'h00500093, 2);
        send_word(32'h00A00113, 0);
        check_load("two_words", 2, hc);

        chk_fetch(32'h8);
        chk_fetch(32'h6);
        chk_fetch(32'h4000);
        chk_fetch(32'h3FFC);
        for (int i = 0; i < 12; i++) begin
            chk_fetch(32'($urandom_range(0, DEPTH - 1)) * 4);
            chk_fetch($urandom);
        end
        tick;

        // Bytes offered in RUN are refused and write nothing
        clear_mon;
        bif.byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.byte_data = 8'($urandom);
            @(negedge clk);
            chk("run_ready", 64'(bif.byte_ready), 64'(0));
            tick;
        end
        bif.byte_valid = 1'b0;
        chk("run_drop_nwr", 64'(wr_cyc_q.size()), 64'(0));

        // load_start from RUN stalls immediately; then an empty program
        pulse_start;
        chk("restart_stall", 64'(cpu_stall), 64'(1));
        chk("restart_ready", 64'(bif.byte_ready), 64'(1));
        send_bytes4(32'd0, 1, hc);
        check_load("zero_words", 0, hc);

        // Header one above capacity
        pulse_start;
        send_bytes4(32'd4097, 1, hc);
        chk("ovf_err", 64'(load_err), 64'(1));
        chk("ovf_stall", 64'(cpu_stall), 64'(1));
        chk("ovf_idle_ready", 64'(bif.byte_ready), 64'(0));
        repeat (3) tick;
        chk("ovf_nwr", 64'(wr_cyc_q.size()), 64'(0));
        chk("ovf_ndone", 64'(done_q.size()), 64'(0));
        chk("ovf_err_sticky", 64'(load_err), 64'(1));

        // A new load clears the error; three words back to back
        do_load("b2b", 3, 0);

        // Reset after two of three words
        pulse_start;
        send_bytes4(32'd3, 0, hc);
        send_word($urandom, 0);
        send_word($urandom, 1);
        repeat (2) tick;
        chk("abort_partial_nwr", 64'(wr_cyc_q.size()), 64'(2));
        do_reset;
        chk("abort_wcount", 64'(word_count), 64'(0));
        chk("abort_stall", 64'(cpu_stall), 64'(1));
        chk("abort_ready", 64'(bif.byte_ready), 64'(0));
        chk("abort_ndone", 64'(done_q.size()), 64'(0));

        // load_start in the middle of a body is ignored
        pulse_start;
        send_bytes4(32'd2, 0, hc);
        send_word($urandom, 1);
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        send_word($urandom, 1);
        check_load("start_in_body", 2, hc);

        do_load("reload_one", 1, 1);

        // Full-capacity header is accepted, then aborted by reset
        pulse_start;
        send_bytes4(32'(DEPTH), 0, hc);
        chk("full_err", 64'(load_err), 64'(0));
        chk("full_ready", 64'(bif.byte_ready), 64'(1));
        chk("full_stall", 64'(cpu_stall), 64'(1));
        send_word($urandom, 0);
        repeat (2) tick;
        chk("full_wcount", 64'(word_count), 64'(1));
        do_reset;

        for (int r = 0; r < 6; r++) do_load("rand", int'($urandom_range(1, 7)), r % 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
